// File: rtl/nested_loop_counter.sv
// nested_loop_counter: NUM_LEVELS chained wrap-at-max counters, level 0 innermost.
// Config handshake loads per-level maxima; inc steps the nest in RUN.
module nested_loop_counter #(
  parameter int NUM_LEVELS = 3,
  parameter int BIT_WIDTH  = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [NUM_LEVELS*BIT_WIDTH-1:0]  cfg_max,
  input  logic                             cfg_wrap,
  input  logic                             inc,
  input  logic                             abort,
  output logic [NUM_LEVELS*BIT_WIDTH-1:0]  count,
  output logic [NUM_LEVELS-1:0]            last,
  output logic [NUM_LEVELS-1:0]            carry,
  output logic                             busy,
  output logic                             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUM_LEVELS-1:0][BIT_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_LEVELS-1:0][BIT_WIDTH-1:0] max_q;
  logic wrap_q;
  logic done_q, done_d;
  logic cfg_acc, step;
  logic acc, cin;

  assign cfg_ready = (state_q == IDLE) || (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign step      = busy && inc && !abort;
  assign count     = cnt_q;
  assign done      = done_q;

  // carry[i] is the prefix-AND of last[0..i] qualified by an accepted inc
  always_comb begin
    last  = '0;
    carry = '0;
    acc   = step;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      last[i]  = (cnt_q[i] == max_q[i]);
      acc      = acc && last[i];
      carry[i] = acc;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    cin     = 1'b1;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (cfg_acc) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (step) begin
      if (carry[NUM_LEVELS-1]) begin
        done_d = 1'b1;
        if (wrap_q) cnt_d = '0;
        else state_d = DONE;
      end else begin
        for (int i = 0; i < NUM_LEVELS; i++) begin
          if (cin) begin
            if (last[i]) cnt_d[i] = '0;
            else cnt_d[i] = cnt_q[i] + BIT_WIDTH'(1);
          end
          cin = cin && last[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      max_q   <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (!abort && cfg_acc) begin
        max_q  <= cfg_max;
        wrap_q <= cfg_wrap;
      end
    end
  end

endmodule

// File: tb/tb_nested_loop_counter.sv
// tb_nested_loop_counter: table vectors plus mixed-radix reference model
// with a scoreboard queue of expected registered outputs.
module tb_nested_loop_counter;

  localparam int NL = 3;
  localparam int BW = 5;
  localparam int W  = NL * BW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [W-1:0]  cfg_max = '0;
  logic          cfg_wrap = 1'b0;
  logic          inc = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  count;
  logic [NL-1:0] last;
  logic [NL-1:0] carry;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  nested_loop_counter #(.NUM_LEVELS(NL), .BIT_WIDTH(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_max   (cfg_max),
    .cfg_wrap  (cfg_wrap),
    .inc       (inc),
    .abort     (abort),
    .count     (count),
    .last      (last),
    .carry     (carry),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [W-1:0]  count;
    logic [NL-1:0] last;
    logic          busy;
    logic          done;
    logic          ready;
  } exp_t;

  typedef struct {
    logic          cv;
    logic [W-1:0]  cm;
    logic          cw;
    logic          ic;
    logic          ab;
    logic [W-1:0]  e_count;
    logic [NL-1:0] e_carry;
    logic          e_busy;
    logic          e_done;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[9];

  int n_cmp = 0;
  int n_bad = 0;

  // model: progress is a linear index decoded as mixed-radix digits
  int   m_st;
  int   m_max[NL];
  int   m_wrap;
  int   m_idx;
  logic m_done;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic int pr(input int k);
    int p = 1;
    for (int j = 0; j <= k; j++) p = p * (m_max[j] + 1);
    return p;
  endfunction

  function automatic logic [W-1:0] m_count();
    logic [W-1:0] r = '0;
    int q = m_idx;
    for (int j = 0; j < NL; j++) begin
      r[j*BW +: BW] = BW'(q % (m_max[j] + 1));
      q = q / (m_max[j] + 1);
    end
    return r;
  endfunction

  function automatic exp_t m_exp();
    exp_t e;
    logic [W-1:0] c = m_count();
    e.count = c;
    for (int j = 0; j < NL; j++)
      e.last[j] = (int'(c[j*BW +: BW]) == m_max[j]);
    e.busy  = (m_st == 1);
    e.done  = m_done;
    e.ready = (m_st != 1);
    return e;
  endfunction

  task automatic m_reset();
    m_st = 0;
    m_wrap = 0;
    m_idx = 0;
    m_done = 1'b0;
    for (int j = 0; j < NL; j++) m_max[j] = 0;
  endtask

  task automatic cyc(input logic cv, input logic [W-1:0] cm,
                     input logic cw, input logic ic, input logic ab,
                     output logic [NL-1:0] c_seen);
    exp_t e;
    logic [NL-1:0] ec;
    bit stp;
    @(negedge clk);
    cfg_valid = cv;
    cfg_max   = cm;
    cfg_wrap  = cw;
    inc       = ic;
    abort     = ab;
    #1;
    stp = (m_st == 1) && ic && !ab;
    for (int i = 0; i < NL; i++)
      ec[i] = stp && ((m_idx % pr(i)) == pr(i) - 1);
    chk("carry", 32'(carry), 32'(ec));
    c_seen = carry;
    m_done = 1'b0;
    if (ab) begin
      m_st = 0;
      m_idx = 0;
    end else if (cv && m_st != 1) begin
      for (int i = 0; i < NL; i++) m_max[i] = int'(cm[i*BW +: BW]);
      m_wrap = int'(cw);
      m_idx = 0;
      m_st = 1;
    end else if (stp) begin
      if (m_idx == pr(NL-1) - 1) begin
        m_done = 1'b1;
        if (m_wrap != 0) m_idx = 0;
        else m_st = 2;
      end else begin
        m_idx++;
      end
    end
    sb.push_back(m_exp());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("count", 32'(count), 32'(e.count));
    chk("last", 32'(last), 32'(e.last));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("done", 32'(done), 32'(e.done));
    chk("cfg_ready", 32'(cfg_ready), 32'(e.ready));
  endtask

  task automatic run_inc(input logic ic, output logic [NL-1:0] cs);
    cyc(1'b0, '0, 1'b0, ic, 1'b0, cs);
  endtask

  localparam logic [W-1:0] MAX213 = {5'd2, 5'd1, 5'd3};

  initial begin
    logic [NL-1:0] cs;
    int c0, c1, c2, dn, streak, done_at, acc_inc;

    tbl[0] = '{1'b1, W'(2), 1'b0, 1'b0, 1'b0, W'(0), 3'b000, 1'b1, 1'b0};
    tbl[1] = '{1'b0, W'(0), 1'b0, 1'b1, 1'b0, W'(1), 3'b000, 1'b1, 1'b0};
    tbl[2] = '{1'b1, W'(7), 1'b1, 1'b1, 1'b0, W'(2), 3'b000, 1'b1, 1'b0};
    tbl[3] = '{1'b0, W'(0), 1'b0, 1'b1, 1'b0, W'(2), 3'b111, 1'b0, 1'b1};
    tbl[4] = '{1'b0, W'(0), 1'b0, 1'b1, 1'b0, W'(2), 3'b000, 1'b0, 1'b0};
    tbl[5] = '{1'b1, W'(3), 1'b1, 1'b0, 1'b0, W'(0), 3'b000, 1'b1, 1'b0};
    tbl[6] = '{1'b0, W'(0), 1'b0, 1'b1, 1'b0, W'(1), 3'b000, 1'b1, 1'b0};
    tbl[7] = '{1'b0, W'(0), 1'b0, 1'b1, 1'b1, W'(0), 3'b000, 1'b0, 1'b0};
    tbl[8] = '{1'b0, W'(0), 1'b0, 1'b1, 1'b0, W'(0), 3'b000, 1'b0, 1'b0};

    m_reset();
    #12;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h1);
    chk("rst_last", 32'(last), 32'h7);
    @(negedge clk);
    rst = 1'b0;

    // priority / ignore vectors
    for (int v = 0; v < 9; v++) begin
      cyc(tbl[v].cv, tbl[v].cm, tbl[v].cw, tbl[v].ic, tbl[v].ab, cs);
      chk($sformatf("tbl%0d_carry", v), 32'(cs), 32'(tbl[v].e_carry));
      chk($sformatf("tbl%0d_count", v), 32'(count), 32'(tbl[v].e_count));
      chk($sformatf("tbl%0d_busy", v), 32'(busy), 32'(tbl[v].e_busy));
      chk($sformatf("tbl%0d_done", v), 32'(done), 32'(tbl[v].e_done));
    end

    // wrap mode, 24 incs
    cyc(1'b1, MAX213, 1'b1, 1'b0, 1'b0, cs);
    c0 = 0; c1 = 0; c2 = 0; dn = 0;
    for (int k = 0; k < 24; k++) begin
      run_inc(1'b1, cs);
      c0 += int'(cs[0]);
      c1 += int'(cs[1]);
      c2 += int'(cs[2]);
      dn += int'(done);
    end
    chk("wrap_carry0_n", 32'(c0), 32'd6);
    chk("wrap_carry1_n", 32'(c1), 32'd3);
    chk("wrap_carry2_n", 32'(c2), 32'd1);
    chk("wrap_done_n", 32'(dn), 32'd1);
    chk("wrap_done_last", 32'(done), 32'd1);
    chk("wrap_busy", 32'(busy), 32'd1);
    run_inc(1'b0, cs);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, cs);

    // stop mode
    cyc(1'b1, MAX213, 1'b0, 1'b0, 1'b0, cs);
    for (int k = 0; k < 24; k++) run_inc(1'b1, cs);
    chk("stop_count", 32'(count), 32'h823);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_ready", 32'(cfg_ready), 32'd1);
    chk("stop_done", 32'(done), 32'd1);
    for (int k = 0; k < 3; k++) begin
      run_inc(1'b1, cs);
      chk("stop_hold_carry", 32'(cs), 32'd0);
      chk("stop_hold_count", 32'(count), 32'h823);
    end

    // restart from DONE, gapped incs
    cyc(1'b1, {5'd0, 5'd0, 5'd5}, 1'b1, 1'b0, 1'b0, cs);
    done_at = -1;
    acc_inc = 0;
    for (int k = 0; k < 14; k++) begin
      run_inc((k % 2) == 0, cs);
      if ((k % 2) == 0) acc_inc++;
      if (done === 1'b1 && done_at < 0) done_at = acc_inc;
    end
    chk("gap_done_at_inc", 32'(done_at), 32'd6);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, cs);

    // degenerate all-zero maxima
    cyc(1'b1, '0, 1'b1, 1'b0, 1'b0, cs);
    streak = 0;
    for (int k = 0; k < 4; k++) begin
      run_inc(1'b1, cs);
      chk("deg_carry", 32'(cs), 32'h7);
      streak += int'(done);
    end
    run_inc(1'b0, cs);
    chk("deg_done_streak", 32'(streak), 32'd4);
    chk("deg_done_end", 32'(done), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, cs);

    // asynchronous reset mid-run
    cyc(1'b1, MAX213, 1'b1, 1'b0, 1'b0, cs);
    for (int k = 0; k < 23; k++) run_inc(1'b1, cs);
    chk("pre_rst_count", 32'(count), 32'h823);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    chk("arst_ready", 32'(cfg_ready), 32'h1);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    run_inc(1'b1, cs);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
